// File: rtl/icache_pkg.sv
// Shared icache definitions: word geometry, line-filler state encoding and
// the line-offset width helper.
package icache_pkg;

   localparam int unsigned WORD_BITS        = 32;
   localparam int unsigned BYTE_OFFSET_BITS = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      RESP,
      DONE
   } fill_state_t;

   function automatic int unsigned offset_bits(input int unsigned num_blocks);
      return $clog2(num_blocks);
   endfunction

endpackage

// File: rtl/icache_line_filler.sv
// Memory-side responder for the icache line-fill port: fetches one line as
// NUM_BLOCKS sequential 32-bit reads and returns it with a one-cycle ready pulse.
module icache_line_filler
   import icache_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 4,
   parameter int unsigned BLOCK_SIZE = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              line_req_valid,
   output logic                              line_req_ready,
   input  logic [31:0]                       line_req_addr,
   output logic [WORD_BITS*NUM_BLOCKS-1:0]   line_req_rdata,
   output logic                              mem_valid,
   input  logic                              mem_ready,
   output logic [31:0]                       mem_addr,
   input  logic [31:0]                       mem_rdata
);

   localparam int unsigned OFFSET_BITS = offset_bits(NUM_BLOCKS);
   localparam logic [31:0] LINE_MASK =
      32'((1 << (OFFSET_BITS + BYTE_OFFSET_BITS)) - 1);
   localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(NUM_BLOCKS - 1);

   generate
      if (BLOCK_SIZE != 4 || NUM_BLOCKS < 2 || (1 << OFFSET_BITS) != NUM_BLOCKS) begin : g_bad_cfg
         $error("icache_line_filler: BLOCK_SIZE must be 4, NUM_BLOCKS a power of two >= 2");
      end
   endgenerate

   fill_state_t             state, state_next;
   logic [OFFSET_BITS-1:0]  cnt;
   logic                    abort;
   logic                    accept;
   logic                    abort_now;
   logic                    last_word;
   logic [NUM_BLOCKS-1:0]   word_we;

   assign mem_valid      = (state == FETCH);
   assign line_req_ready = (state == RESP);
   assign accept         = mem_valid & mem_ready;
   // A drop seen on the accept edge itself counts the same as an earlier one.
   assign abort_now      = abort | ~line_req_valid;
   assign last_word      = (cnt == LAST_WORD);

   always_comb begin
      word_we = '0;
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
         word_we[i] = accept && (cnt == OFFSET_BITS'(i));
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (line_req_valid) state_next = FETCH;
         FETCH: if (accept) begin
                   if (abort_now)      state_next = DONE;
                   else if (last_word) state_next = RESP;
                end
         RESP:  state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         mem_addr       <= '0;
         abort          <= 1'b0;
         line_req_rdata <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (word_we[i]) line_req_rdata[WORD_BITS*i +: WORD_BITS] <= mem_rdata;
         end
         unique case (state)
            IDLE: if (line_req_valid) begin
                     mem_addr <= line_req_addr & ~LINE_MASK;
                     cnt      <= '0;
                     abort    <= 1'b0;
                  end
            FETCH: if (accept) begin
                      if (abort_now) begin
                         abort <= 1'b0;
                      end else if (!last_word) begin
                         cnt      <= cnt + OFFSET_BITS'(1);
                         mem_addr <= mem_addr + 32'd4;
                      end
                   end else if (!line_req_valid) begin
                      abort <= 1'b1;
                   end
            default: ;
         endcase
      end
   end

endmodule
